// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RV32I-subset datapath, with a retired-instruction counter.
// Build option: define ILLEGAL_TRAP_EN to send unknown opcodes to a TRAP state held until reset.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_TRAP     = 4'd10;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0]       state_reg, state_next;
  logic [CNT_W-1:0] retired_reg;
  logic [2:0]       alu_funct;

  // Shared funct3 decode; sub is only honoured for register-register ops.
  always_comb begin
    alu_funct = ALU_ADD;
    case (funct3)
      3'b000:  alu_funct = (funct7_5 && state_reg == S_EXECR) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_funct = ALU_AND;
      3'b110:  alu_funct = ALU_OR;
      3'b010:  alu_funct = ALU_SLT;
      default: alu_funct = ALU_ADD;
    endcase
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECR;
          OP_ITYPE:     state_next = S_EXECI;
          OP_BRANCH:    state_next = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
          default:      state_next = S_TRAP;
`else
          default:      state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_next = S_TRAP;
`endif
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    case (state_reg)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_funct;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_funct;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
      end
      default: ;
    endcase
  end

  // Any return to FETCH from a later state marks one retired instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg != S_FETCH && state_next == S_FETCH)
        retired_reg <= retired_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign state_dbg = state_reg;
  assign retired   = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus latency/reset sequences.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        zero;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [2:0]  alu_control;
  logic [3:0]  state_dbg;
  logic [31:0] retired;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .state_dbg(state_dbg), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Control word: {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, alu_control}
  localparam logic [14:0] C_FETCH    = {5'b10010, 2'b10, 2'b00, 2'b10, 3'b000};
  localparam logic [14:0] C_DECODE   = {5'b00000, 2'b00, 2'b01, 2'b01, 3'b000};
  localparam logic [14:0] C_MEMADR   = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b000};
  localparam logic [14:0] C_MEMREAD  = {5'b01000, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] C_MEMWB    = {5'b00001, 2'b01, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] C_MEMWRITE = {5'b01100, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] C_ALUWB    = {5'b00001, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] C_TRAP     = 15'd0;

  function automatic logic [14:0] c_exec(input logic [1:0] srcb, input logic [2:0] alu);
    return {5'b00000, 2'b00, 2'b10, srcb, alu};
  endfunction

  function automatic logic [14:0] c_branch(input logic pcw);
    return {pcw, 4'b0000, 2'b00, 2'b10, 2'b00, 3'b001};
  endfunction

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [3:0]  st;
    logic [14:0] ctrl;
    logic [7:0]  ret;
  } vec_t;

  vec_t vecs[$];
  int   r = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [14:0] ctrl_act;

  assign ctrl_act = {pc_write, adr_src, mem_write, ir_write, reg_write,
                     result_src, alu_src_a, alu_src_b, alu_control};

  task automatic mk(input logic rst, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                    input logic z, input logic [3:0] st, input logic [14:0] ctrl);
    vec_t v;
    v.rst = rst; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z;
    v.st = st; v.ctrl = ctrl; v.ret = 8'(r);
    vecs.push_back(v);
  endtask

  task automatic alu_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic [2:0] alu);
    mk(0, op, f3, f7, 0, 4'd0, C_FETCH);
    mk(0, op, f3, f7, 0, 4'd1, C_DECODE);
    if (op == OP_R) mk(0, op, f3, f7, 0, 4'd6, c_exec(2'b00, alu));
    else            mk(0, op, f3, f7, 0, 4'd7, c_exec(2'b01, alu));
    mk(0, op, f3, f7, 0, 4'd8, C_ALUWB);
    r++;
  endtask

  task automatic br_instr(input logic [2:0] f3, input logic z, input logic pcw);
    mk(0, OP_B, f3, 0, z, 4'd0, C_FETCH);
    mk(0, OP_B, f3, 0, z, 4'd1, C_DECODE);
    mk(0, OP_B, f3, 0, z, 4'd9, c_branch(pcw));
    r++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Caller is positioned just after a falling edge with the FSM in FETCH.
  task automatic measure(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic z, input int exp_cyc, input int exp_mw);
    int cyc = 0, mw = 0, both = 0;
    opcode = op; funct3 = f3; funct7_5 = 1'b0; zero = z;
    #1;
    do begin
      if (mem_write) mw++;
      if (mem_write && ir_write) both++;
      @(negedge clk); #1;
      cyc++;
    end while (state_dbg != 4'd0 && cyc < 16);
    check({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check({name, "_memwrite_cycles"}, 32'(mw), 32'(exp_mw));
    check({name, "_mem_ir_overlap"}, 32'(both), 32'd0);
  endtask

  initial begin
    reset = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0;

    // lw
    mk(0, OP_LW, 3'b010, 0, 0, 4'd0, C_FETCH);
    mk(0, OP_LW, 3'b010, 0, 0, 4'd1, C_DECODE);
    mk(0, OP_LW, 3'b010, 0, 0, 4'd2, C_MEMADR);
    mk(0, OP_LW, 3'b010, 0, 0, 4'd3, C_MEMREAD);
    mk(0, OP_LW, 3'b010, 0, 0, 4'd4, C_MEMWB);
    r++;
    // sw
    mk(0, OP_SW, 3'b010, 0, 0, 4'd0, C_FETCH);
    mk(0, OP_SW, 3'b010, 0, 0, 4'd1, C_DECODE);
    mk(0, OP_SW, 3'b010, 0, 0, 4'd2, C_MEMADR);
    mk(0, OP_SW, 3'b010, 0, 0, 4'd5, C_MEMWRITE);
    r++;
    alu_instr(OP_R, 3'b000, 1'b1, 3'b001);   // sub
    alu_instr(OP_R, 3'b111, 1'b0, 3'b010);   // and
    alu_instr(OP_R, 3'b010, 1'b0, 3'b101);   // slt
    alu_instr(OP_R, 3'b001, 1'b0, 3'b000);   // unmapped funct3 -> add
    alu_instr(OP_I, 3'b000, 1'b1, 3'b000);   // addi never subtracts
    alu_instr(OP_I, 3'b110, 1'b0, 3'b011);   // ori
    br_instr(3'b001, 1'b0, 1'b1);            // bne taken
    br_instr(3'b001, 1'b1, 1'b0);            // bne not taken
    br_instr(3'b000, 1'b1, 1'b1);            // beq taken
    br_instr(3'b000, 1'b0, 1'b0);            // beq not taken
    br_instr(3'b100, 1'b0, 1'b0);            // other funct3 never taken
    // reset arriving during MEMWRITE
    mk(0, OP_SW, 3'b010, 0, 0, 4'd0, C_FETCH);
    mk(0, OP_SW, 3'b010, 0, 0, 4'd1, C_DECODE);
    mk(0, OP_SW, 3'b010, 0, 0, 4'd2, C_MEMADR);
    mk(1, OP_SW, 3'b010, 0, 0, 4'd5, C_MEMWRITE);
    r = 0;
    mk(0, OP_SW, 3'b010, 0, 0, 4'd0, C_FETCH);
    mk(0, OP_SW, 3'b010, 0, 0, 4'd1, C_DECODE);
    mk(0, OP_SW, 3'b010, 0, 0, 4'd2, C_MEMADR);
    mk(0, OP_SW, 3'b010, 0, 0, 4'd5, C_MEMWRITE);
    r++;
    // illegal opcode
    mk(0, OP_BAD, 3'b000, 0, 0, 4'd0, C_FETCH);
    mk(0, OP_BAD, 3'b000, 0, 0, 4'd1, C_DECODE);
`ifdef ILLEGAL_TRAP_EN
    mk(0, OP_BAD, 3'b000, 0, 0, 4'd10, C_TRAP);
    mk(0, OP_BAD, 3'b000, 0, 0, 4'd10, C_TRAP);
    mk(0, OP_LW,  3'b000, 0, 0, 4'd10, C_TRAP);
`else
    r++;
    mk(0, OP_BAD, 3'b000, 0, 0, 4'd0, C_FETCH);
`endif

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; opcode = vecs[i].op; funct3 = vecs[i].f3;
      funct7_5 = vecs[i].f7; zero = vecs[i].z;
      #1;
      n_vec++;
      if ({state_dbg, ctrl_act, retired[7:0]} !== {vecs[i].st, vecs[i].ctrl, vecs[i].ret}) begin
        n_err++;
        $display("FAIL vec%0d: got state=%0d ctrl=%b retired=%0d, expected state=%0d ctrl=%b retired=%0d",
                 i, state_dbg, ctrl_act, retired, vecs[i].st, vecs[i].ctrl, vecs[i].ret);
      end
    end

    // Reset from wherever the table left the FSM, then time whole instructions.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_state", 32'(state_dbg), 32'd0);
    check("reset_retired", retired, 32'd0);
    measure("lw",  OP_LW, 3'b010, 1'b0, 5, 0);
    measure("sw",  OP_SW, 3'b010, 1'b0, 4, 1);
    measure("add", OP_R,  3'b000, 1'b0, 4, 0);
    measure("addi", OP_I, 3'b000, 1'b0, 4, 0);
    measure("beq", OP_B,  3'b000, 1'b1, 3, 0);
    check("retired_after_seq", retired, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
